// File: rtl/axi_pkg.sv
// Shared AXI types and burst address arithmetic used by the memory slave's
// read and write channel FSMs.
package axi_pkg;

   typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11} burst_t;
   typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
   typedef enum logic {R_IDLE, R_DATA} rd_state_t;

   // WRAP keeps the bits above the wrap span and steps only the bits inside it.
   function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                             input burst_t burst, input logic [7:0] bytes);
      logic [31:0] span;
      logic [31:0] mask;
      logic [31:0] step;
      span = (32'(len) + 32'd1) * 32'(bytes);
      mask = span - 32'd1;
      step = addr + 32'(bytes);
      case (burst)
         INCR:    next_addr = step;
         WRAP:    next_addr = (addr & ~mask) | (step & mask);
         default: next_addr = addr;
      endcase
   endfunction

   function automatic logic burst_legal(input logic [7:0] len, input burst_t burst);
      case (burst)
         WRAP:    burst_legal = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
         RSVD:    burst_legal = 1'b0;
         default: burst_legal = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/axi_burst_mem_slave_if.sv
// AXI4 (no ID) bus bundle between a burst master and the memory slave.
// Every channel transfers on a clock edge where valid and ready are both 1;
// a source holds valid and its payload stable until that edge.
interface axi_burst_mem_slave_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   awaddr;
   logic [7:0]          awlen;
   logic [1:0]          awburst;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic [7:0]          arlen;
   logic [1:0]          arburst;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rlast;
   logic                rvalid;
   logic                rready;

   modport slave (
      input  awaddr, awlen, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
             araddr, arlen, arburst, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
   );

   modport master (
      output awaddr, awlen, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
             araddr, arlen, arburst, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/axi_mem_ram.sv
// Single-clock word RAM: one byte-enabled write port and one synchronous
// read port that returns the old word on a same-cycle write (read-first).
module axi_mem_ram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                we,
   input  logic [IDX_W-1:0]    waddr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                re,
   input  logic [IDX_W-1:0]    raddr,
   output logic [DATA_W-1:0]   rdata
);
   logic [DATA_W-1:0] mem [DEPTH];

   // rdata holds its value whenever re is low, so a stalled beat stays stable.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < DATA_W / 8; b++) begin
            if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 burst memory slave: independent write (AW/W/B) and read (AR/R) FSMs
// in front of a word RAM, with FIXED/INCR/WRAP address generation.
module axi_burst_mem_slave import axi_pkg::*; #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024
) (
   input  logic               aclk,
   input  logic               areset,
   axi_burst_mem_slave_if.slave bus,
   output wr_state_t          wr_state,
   output rd_state_t          rd_state
);
   localparam int BYTES = DATA_W / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int IDX_W = $clog2(DEPTH);

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return 32'(a) < 32'(DEPTH * BYTES);
   endfunction

   logic [ADDR_W-1:0] waddr, raddr, r_next;
   logic [7:0]        wlen, wcnt, rlen, rcnt;
   burst_t            wburst, rburst;
   logic              werr, rerr;
   logic              awready_q, wready_q, bvalid_q, arready_q, rvalid_q, rlast_q;
   resp_t             bresp_q;
   logic              w_fire, w_last_beat, w_ok, w_beat_err, ram_we;
   logic              ar_fire, r_fire, ram_re;
   logic [IDX_W-1:0]  ram_raddr;
   logic [DATA_W-1:0] ram_q;

   assign w_fire      = (wr_state == W_DATA) && bus.wvalid;
   assign w_last_beat = (wcnt == wlen);
   assign w_ok        = burst_legal(wlen, wburst) && in_range(waddr);
   assign w_beat_err  = !w_ok || (bus.wlast != w_last_beat);
   assign ram_we      = w_fire && w_ok;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wr_state  <= W_IDLE;
         awready_q <= 1'b1;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= OKAY;
         waddr     <= '0;
         wlen      <= '0;
         wburst    <= FIXED;
         wcnt      <= '0;
         werr      <= 1'b0;
      end else begin
         case (wr_state)
            W_IDLE: if (bus.awvalid) begin
               waddr     <= bus.awaddr;
               wlen      <= bus.awlen;
               wburst    <= burst_t'(bus.awburst);
               wcnt      <= '0;
               werr      <= 1'b0;
               awready_q <= 1'b0;
               wready_q  <= 1'b1;
               wr_state  <= W_DATA;
            end
            W_DATA: if (bus.wvalid) begin
               if (w_last_beat) begin
                  wready_q <= 1'b0;
                  bvalid_q <= 1'b1;
                  bresp_q  <= (werr || w_beat_err) ? SLVERR : OKAY;
                  wr_state <= W_RESP;
               end else begin
                  wcnt  <= wcnt + 8'd1;
                  waddr <= ADDR_W'(next_addr(32'(waddr), wlen, wburst, 8'(BYTES)));
                  werr  <= werr || w_beat_err;
               end
            end
            W_RESP: if (bus.bready) begin
               bvalid_q  <= 1'b0;
               bresp_q   <= OKAY;
               awready_q <= 1'b1;
               wr_state  <= W_IDLE;
            end
            default: wr_state <= W_IDLE;
         endcase
      end
   end

   // The RAM is read one beat ahead so the next word is ready the cycle after a fire.
   assign r_next    = ADDR_W'(next_addr(32'(raddr), rlen, rburst, 8'(BYTES)));
   assign ar_fire   = (rd_state == R_IDLE) && bus.arvalid;
   assign r_fire    = rvalid_q && bus.rready;
   assign ram_re    = ar_fire || (r_fire && !rlast_q);
   assign ram_raddr = (rd_state == R_IDLE) ? bus.araddr[OFF_W +: IDX_W] : r_next[OFF_W +: IDX_W];

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         rd_state  <= R_IDLE;
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rerr      <= 1'b0;
         raddr     <= '0;
         rlen      <= '0;
         rburst    <= FIXED;
         rcnt      <= '0;
      end else begin
         case (rd_state)
            R_IDLE: if (bus.arvalid) begin
               raddr     <= bus.araddr;
               rlen      <= bus.arlen;
               rburst    <= burst_t'(bus.arburst);
               rcnt      <= '0;
               rvalid_q  <= 1'b1;
               rlast_q   <= (bus.arlen == 8'd0);
               rerr      <= !burst_legal(bus.arlen, burst_t'(bus.arburst)) || !in_range(bus.araddr);
               arready_q <= 1'b0;
               rd_state  <= R_DATA;
            end
            R_DATA: if (r_fire) begin
               if (rlast_q) begin
                  rvalid_q  <= 1'b0;
                  rlast_q   <= 1'b0;
                  rerr      <= 1'b0;
                  arready_q <= 1'b1;
                  rd_state  <= R_IDLE;
               end else begin
                  raddr   <= r_next;
                  rcnt    <= rcnt + 8'd1;
                  rlast_q <= ((rcnt + 8'd1) == rlen);
                  rerr    <= !burst_legal(rlen, rburst) || !in_range(r_next);
               end
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

   axi_mem_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
      .clk   (aclk),
      .we    (ram_we),
      .waddr (waddr[OFF_W +: IDX_W]),
      .wdata (bus.wdata),
      .wstrb (bus.wstrb),
      .re    (ram_re),
      .raddr (ram_raddr),
      .rdata (ram_q)
   );

   assign bus.awready = awready_q;
   assign bus.wready  = wready_q;
   assign bus.bvalid  = bvalid_q;
   assign bus.bresp   = bresp_q;
   assign bus.arready = arready_q;
   assign bus.rvalid  = rvalid_q;
   assign bus.rlast   = rlast_q;
   assign bus.rresp   = (rvalid_q && rerr) ? SLVERR : OKAY;
   assign bus.rdata   = (rvalid_q && !rerr) ? ram_q : '0;
endmodule
